// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single pipelined memory port.
// Data wins by default; a waiting fetch is forced through after MAX_STREAK data grants.
module mem_arbiter #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MAX_STREAK = 2
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,

  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] StreakMax = 3'(MAX_STREAK);

  logic [2:0]        streak_q, streak_d;
  logic [RD_LAT-1:0] ret_valid_q, ret_valid_d;
  logic [RD_LAT-1:0] ret_fetch_q, ret_fetch_d;

  logic fetch_first;
  logic rd_push;
  logic ret_valid;
  logic ret_fetch;

  // Grants are gated by rst_n so nothing leaks onto the memory bus during reset.
  always_comb begin
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    fetch_first = (streak_q == StreakMax);
    if (rst_n) begin
      if (if_req && (!d_req || fetch_first)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Streak counts data grants that overtook a pending fetch.
  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = 3'd0;
    end else if (d_gnt && (streak_q < StreakMax)) begin
      streak_d = streak_q + 3'd1;
    end
  end

  // Every grant pushes one entry; stores push an invalid one to keep timing uniform.
  always_comb begin
    rd_push        = if_gnt | (d_gnt & ~d_we);
    ret_valid_d    = ret_valid_q;
    ret_fetch_d    = ret_fetch_q;
    ret_valid_d[0] = rd_push;
    ret_fetch_d[0] = if_gnt;
    for (int i = 1; i < RD_LAT; i++) begin
      ret_valid_d[i] = ret_valid_q[i-1];
      ret_fetch_d[i] = ret_fetch_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q    <= 3'd0;
      ret_valid_q <= '0;
      ret_fetch_q <= '0;
    end else begin
      streak_q    <= streak_d;
      ret_valid_q <= ret_valid_d;
      ret_fetch_q <= ret_fetch_d;
    end
  end

  always_comb begin
    ret_valid = ret_valid_q[RD_LAT-1];
    ret_fetch = ret_fetch_q[RD_LAT-1];
    if_rvalid = ret_valid & ret_fetch;
    d_rvalid  = ret_valid & ~ret_fetch;
    if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    d_rdata   = d_rvalid ? mem_rdata : 32'h0;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1: cycles from read issue to mem_rdata valid; legal range 1-4.
REQ-002 Parameter MAX_STREAK, default 2: consecutive data grants allowed while a fetch waits; legal range 1-7.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 if_req  in  1  instruction-fetch read request; held until granted.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid  out  1  if_rdata valid.
REQ-009 if_rdata  out  32  fetch read data.
REQ-010 d_req  in  1  data-port request (load or store); held until granted.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  32  data byte address.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_gnt  out  1  data request accepted this cycle.
REQ-015 d_rvalid  out  1  d_rdata valid (loads only).
REQ-016 d_rdata  out  32  load data.
REQ-017 mem_en  out  1  memory access strobe.
REQ-018 mem_we  out  1  memory write enable.
REQ-019 mem_addr  out  32  memory address.
REQ-020 mem_wdata  out  32  memory write data.
REQ-021 mem_rdata  in  32  memory read data, valid RD_LAT cycles after a read strobe.

Function
REQ-022 At most one grant per cycle; if_gnt and d_gnt combinational from requests and registered state, never both high.
REQ-023 mem_en = if_gnt | d_gnt; mem_we = d_gnt & d_we; mem_addr/mem_wdata driven from the granted port (mem_wdata = d_wdata; mem_addr = 0, mem_wdata = 0 when idle).
REQ-024 Priority: data port wins by default; fetch wins when streak counter == MAX_STREAK.
REQ-025 Streak counter (3 bits): increments on each d_gnt while if_req high; clears on if_gnt or when if_req low; saturates at MAX_STREAK.
REQ-026 Only one requester active -> it is granted same cycle, independent of streak.
REQ-027 Issue pipelined: a new grant is legal every cycle, including while reads are outstanding.
REQ-028 Return tracking: RD_LAT-deep shift register of {valid, owner}; entry pushed on every read grant (if_gnt, or d_gnt with d_we = 0); stores push an invalid entry.
REQ-029 When the shift-register output is valid: owner fetch -> if_rvalid = 1, if_rdata = mem_rdata; owner data -> d_rvalid = 1, d_rdata = mem_rdata; exactly RD_LAT cycles after the grant.
REQ-030 if_rdata/d_rdata = 0 when the corresponding rvalid is 0.
REQ-031 Responses return in issue order; no reordering, no back-pressure on the response side.
REQ-032 Stores complete at grant; no response strobe generated.
REQ-033 Requests and address/data sampled only in the grant cycle; changes after grant ignored.

Reset
REQ-034 rst_n low asynchronously clears shift register and streak counter; all outputs 0 while in reset (grants forced low).
REQ-035 Reads outstanding at reset assertion are discarded; no rvalid issued for them after release.
REQ-036 First grant possible in the first cycle after rst_n deasserts.

Verification
REQ-037 if_req=1 only, if_addr=0x100, RD_LAT=1 -> if_gnt=1, mem_en=1, mem_addr=0x100 same cycle; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-038 if_req and d_req (load) both held 4 cycles, MAX_STREAK=2 -> grant order D,D,I,D; rvalids in same order 1 cycle later.
REQ-039 d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> d_gnt=1, mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF; no d_rvalid follows.
REQ-040 RD_LAT=3, back-to-back grants I,D,I -> if_rvalid, d_rvalid, if_rvalid on cycles +3,+4,+5 with matching data.
REQ-041 rst_n pulsed low 1 cycle after a fetch grant with RD_LAT=2 -> no if_rvalid ever for that fetch; outputs 0 during reset.
REQ-042 Random req/we/addr for 10k cycles vs. reference model -> never both grants, every read returns to correct owner after RD_LAT, fetch never waits more than MAX_STREAK+1 cycles.
